keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x3 keypad scanner: walks an active-low column strobe, samples the synchronized
// rows once per column, and debounces the per-frame key code over DEB_SCANS frames.
module keypad_scan #(
  parameter int SCAN_DIV  = 1000,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [2:0] col_n,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_strobe
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SCANS + 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;

  logic [3:0]    sync1_q, sync2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    ptr_q;
  logic [3:0]    hits0_q, hits1_q;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    kv_q, kv_d;
  logic          kvld_q, kvld_d, stb_q, stb_d;
  logic          last_dwell, frame_end;
  logic [3:0]    code;

  assign last_dwell = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_end  = last_dwell && (ptr_q == 2'd2);
  assign col_n      = ~(3'b001 << ptr_q);
  assign cnt_inc    = cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      dwell_q <= '0;
      ptr_q   <= 2'd0;
      hits0_q <= '0;
      hits1_q <= '0;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
      if (last_dwell) begin
        dwell_q <= '0;
        ptr_q   <= (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        if (ptr_q == 2'd0) hits0_q <= ~sync2_q;
        if (ptr_q == 2'd1) hits1_q <= ~sync2_q;
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  // Column 2 is not stored: at frame-end its rows are read live from the synchronizer.
  always_comb begin
    int   nhit;
    logic hit;
    nhit = 0;
    hit  = 1'b0;
    code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        hit = (c == 0) ? hits0_q[r] : (c == 1) ? hits1_q[r] : ~sync2_q[r];
        if (hit) begin
          nhit = nhit + 1;
          code = 4'(r * 3 + c + 1);
        end
      end
    end
    if (nhit != 1) code = 4'd0;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    kv_d    = kv_q;
    kvld_d  = kvld_q;
    stb_d   = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: if (code != 4'd0) begin
          cand_d  = code;
          cnt_d   = CW'(1);
          state_d = CONFIRM;
        end
        CONFIRM: begin
          if (code == 4'd0) begin
            state_d = IDLE;
          end else if (code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEB_SCANS)) begin
              state_d = PRESSED;
              kv_d    = cand_q;
              kvld_d  = 1'b1;
              stb_d   = 1'b1;
            end
          end else begin
            cand_d = code;
            cnt_d  = CW'(1);
          end
        end
        PRESSED: if (code != cand_q) begin
          state_d = RELEASE;
          cnt_d   = CW'(1);
        end
        RELEASE: begin
          if (code == cand_q) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEB_SCANS)) begin
              state_d = IDLE;
              kv_d    = 4'd0;
              kvld_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
      kv_q    <= 4'd0;
      kvld_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      kvld_q  <= kvld_d;
      stb_q   <= stb_d;
    end
  end

  assign key_value  = kv_q;
  assign key_valid  = kvld_q;
  assign key_strobe = stb_q;
endmodule
